// File: rtl/snake_head_stepper_pkg.sv
// Shared direction codes, FSM states and grid defaults for the snake head stepper.
package snake_head_stepper_pkg;

  typedef enum logic [1:0] {
    DIR_TOP   = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_e;

  localparam int unsigned DEF_GRID_W = 40;
  localparam int unsigned DEF_GRID_H = 30;

  // Opposing directions differ only in the low bit of the code.
  function automatic dir_e opposite_dir(input dir_e d);
    return dir_e'(2'(d) ^ 2'b01);
  endfunction

endpackage

// File: rtl/snake_head_stepper_game_tick_gen.sv
// Game tick counter: counts while run_i, holds otherwise, clear_i zeroes it;
// term_c flags the terminal count of a running cycle.
module snake_head_stepper_game_tick_gen #(
  parameter int unsigned TICK_DIV = 25_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic run_i,
  input  logic clear_i,
  output logic term_c
);

  localparam int unsigned CNT_W = $clog2(TICK_DIV);

  logic [CNT_W-1:0] cnt_q;

  assign term_c = run_i && (cnt_q == CNT_W'(TICK_DIV - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (clear_i) begin
      cnt_q <= '0;
    end else if (run_i) begin
      cnt_q <= term_c ? '0 : cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/snake_head_stepper.sv
// Snake head stepper: filters direction requests against the committed heading,
// advances the head with toroidal wrap on each game tick and pulses step.
module snake_head_stepper
  import snake_head_stepper_pkg::*;
#(
  parameter int unsigned GRID_W   = DEF_GRID_W,
  parameter int unsigned GRID_H   = DEF_GRID_H,
  parameter int unsigned X_W      = 6,
  parameter int unsigned Y_W      = 5,
  parameter int unsigned TICK_DIV = 25_000_000
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [1:0]     dir_in,
  input  logic           start,
  input  logic           pause,
  input  logic           stop,
  output logic [X_W-1:0] head_x,
  output logic [Y_W-1:0] head_y,
  output logic [1:0]     cur_dir,
  output logic           step,
  output logic           running
);

  state_e         state_q;
  dir_e           cur_dir_q, pending_q;
  logic [X_W-1:0] head_x_q;
  logic [Y_W-1:0] head_y_q;
  logic           step_q, running_q;

  dir_e           req_dir_c, eff_dir_c;
  logic           legal_c, run_c, clear_c, tick_c;
  logic [X_W-1:0] head_x_d;
  logic [Y_W-1:0] head_y_d;

  // Stop and pause both pre-empt a terminal tick in the same cycle.
  assign run_c   = (state_q == ST_RUN) && !stop && !pause;
  assign clear_c = stop || (state_q == ST_IDLE);

  snake_head_stepper_game_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk     (clk),
    .reset   (reset),
    .run_i   (run_c),
    .clear_i (clear_c),
    .term_c  (tick_c)
  );

  // Reversal is judged against the committed heading, not the pending request.
  always_comb begin
    req_dir_c = dir_e'(dir_in);
    legal_c   = (req_dir_c != opposite_dir(cur_dir_q));
    eff_dir_c = legal_c ? req_dir_c : pending_q;
  end

  always_comb begin
    head_x_d = head_x_q;
    head_y_d = head_y_q;
    case (eff_dir_c)
      DIR_TOP:   head_y_d = (head_y_q == '0) ? Y_W'(GRID_H - 1) : head_y_q - Y_W'(1);
      DIR_DOWN:  head_y_d = (head_y_q == Y_W'(GRID_H - 1)) ? '0 : head_y_q + Y_W'(1);
      DIR_LEFT:  head_x_d = (head_x_q == '0) ? X_W'(GRID_W - 1) : head_x_q - X_W'(1);
      DIR_RIGHT: head_x_d = (head_x_q == X_W'(GRID_W - 1)) ? '0 : head_x_q + X_W'(1);
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      running_q <= 1'b0;
      head_x_q  <= X_W'(GRID_W / 2);
      head_y_q  <= Y_W'(GRID_H / 2);
      cur_dir_q <= DIR_TOP;
      pending_q <= DIR_TOP;
      step_q    <= 1'b0;
    end else begin
      pending_q <= eff_dir_c;
      step_q    <= tick_c;
      if (tick_c) begin
        head_x_q  <= head_x_d;
        head_y_q  <= head_y_d;
        cur_dir_q <= eff_dir_c;
      end
      // Priority stop > pause > start; running mirrors the next state.
      case (state_q)
        ST_IDLE: begin
          if (!stop && !pause && start) begin
            state_q   <= ST_RUN;
            running_q <= 1'b1;
          end
        end
        ST_RUN: begin
          if (stop) begin
            state_q   <= ST_IDLE;
            running_q <= 1'b0;
          end else if (pause) begin
            state_q   <= ST_PAUSE;
            running_q <= 1'b0;
          end
        end
        ST_PAUSE: begin
          if (stop) begin
            state_q <= ST_IDLE;
          end else if (!pause) begin
            state_q   <= ST_RUN;
            running_q <= 1'b1;
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          running_q <= 1'b0;
        end
      endcase
    end
  end

  assign head_x  = head_x_q;
  assign head_y  = head_y_q;
  assign cur_dir = 2'(cur_dir_q);
  assign step    = step_q;
  assign running = running_q;

endmodule
